// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single full-subtractor stage with a registered borrow.
// It uses a valid/ready handshake on both the operand side and the result side.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_br;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_ovf;

    logic               w_d;
    logic               w_br_next;
    logic               w_last;
    logic               w_ovf;

    // One-bit full subtractor: difference bit
    function automatic logic fs_diff(input logic ai, input logic bi, input logic br);
        return ai ^ bi ^ br;
    endfunction

    // One-bit full subtractor: borrow out of this bit position
    function automatic logic fs_borrow(input logic ai, input logic bi, input logic br);
        return (~ai & bi) | (~(ai ^ bi) & br);
    endfunction

    // r_a[0]/r_b[0] are the operand bits being processed this cycle; on the
    // final SHIFT cycle they are the operand MSBs, which the overflow test needs.
    assign w_d       = fs_diff(r_a[0], r_b[0], r_br);
    assign w_br_next = fs_borrow(r_a[0], r_b[0], r_br);
    assign w_last    = (r_state == SHIFT) && (r_cnt == LAST_BIT);
    assign w_ovf     = (r_a[0] ^ r_b[0]) & (w_d ^ r_a[0]);

    // Control FSM plus the registered result and handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
            r_br        <= 1'b0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_br       <= bin;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_br  <= w_br_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        // The shift register holds the first WIDTH-1 diff bits
                        // in its upper part; the current bit completes the MSB.
                        r_diff      <= {w_d, r_a[WIDTH-1:1]};
                        r_bout      <= w_br_next;
                        r_ovf       <= w_ovf;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    // Operand shift registers: loaded on acceptance and shifted right in SHIFT.
    // Diff bits refill r_a from the top as the minuend bits are consumed.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && in_valid) begin
            r_a <= a;
            r_b <= b;
        end else if (r_state == SHIFT) begin
            r_a <= {w_d, r_a[WIDTH-1:1]};
            r_b <= {1'b0, r_b[WIDTH-1:1]};
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=4.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for in_ready, present operands for one accepting edge,
    // then scramble the operand inputs to show they are ignored afterwards.
    task automatic send(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic bi);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        a        = av;
        b        = bv;
        bin      = bi;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = ~av;
        b        = ~bv;
        bin      = ~bi;
    endtask

    // Count cycles from the accepting edge until out_valid (bounded).
    task automatic wait_result(input string tag, input logic [W-1:0] ed, input logic eb,
                               input logic eo);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_diff"}, 32'(diff), 32'(ed));
        chk({tag, "_bout"}, 32'(bout), 32'(eb));
        chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
    endtask

    initial begin
        int  rise0;
        int  rise1;
        int  nrise;
        logic prev_v;
        logic seen_v;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        bin       = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        tick();

        // 9 - 3 - 0 = 6, signed -7 - 3 overflows
        send("t1", 4'd9, 4'd3, 1'b0);
        chk("t1_busy", 32'(in_ready), 32'd0);
        wait_result("t1", 4'h6, 1'b0, 1'b1);
        tick();
        chk("t1_valid_fall", 32'(out_valid), 32'd0);
        chk("t1_idle_ready", 32'(in_ready), 32'd1);
        chk("t1_diff_kept", 32'(diff), 32'h6);

        // 3 - 9 - 0 = 0xA with 3 cycles of backpressure
        out_ready = 1'b0;
        send("t2", 4'd3, 4'd9, 1'b0);
        wait_result("t2", 4'hA, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_diff", 32'(diff), 32'hA);
            chk("bp_bout", 32'(bout), 32'd1);
            chk("bp_ovf", 32'(overflow), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        tick();
        chk("bp_single_xfer", 32'(out_valid), 32'd0);
        chk("bp_diff_kept", 32'(diff), 32'hA);

        // 0 - 0 - 1 = 0xF, borrow out, no overflow
        send("t3", 4'd0, 4'd0, 1'b1);
        wait_result("t3", 4'hF, 1'b1, 1'b0);
        tick();

        // 8 - 1 = 7 and 7 - 8 = 0xF, both signed overflow
        send("t4a", 4'd8, 4'd1, 1'b0);
        wait_result("t4a", 4'h7, 1'b0, 1'b1);
        tick();
        send("t4b", 4'd7, 4'd8, 1'b0);
        wait_result("t4b", 4'hF, 1'b1, 1'b1);
        tick();

        // Back-to-back with in_valid and out_ready held high: one result per 6 cycles
        a        = 4'd8;
        b        = 4'd1;
        bin      = 1'b0;
        in_valid = 1'b1;
        rise0    = -1;
        rise1    = -1;
        nrise    = 0;
        prev_v   = out_valid;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid && !prev_v) begin
                if (nrise == 0) rise0 = i;
                else if (nrise == 1) rise1 = i;
                nrise++;
            end
            prev_v = out_valid;
        end
        in_valid = 1'b0;
        chk("tput_period", 32'(rise1 - rise0), 32'd6);
        chk("tput_diff", 32'(diff), 32'h7);

        // Reset during the second SHIFT cycle discards the transaction
        send("t5", 4'd9, 4'd3, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_diff", 32'(diff), 32'd0);
        chk("mid_rst_bout", 32'(bout), 32'd0);
        seen_v = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) seen_v = 1'b1;
        end
        chk("mid_rst_no_valid", 32'(seen_v), 32'd0);

        // Fresh transaction after reset: 5 - 2 = 3
        send("t6", 4'd5, 4'd2, 1'b0);
        wait_result("t6", 4'h3, 1'b0, 1'b0);
        tick();
        chk("t6_valid_fall", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
